regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request/ready handshakes, register-file write port and pending-write mask.
interface regfile_wb_arbiter_if #(
  parameter int unsigned ADDR_SIZE  = 4,
  parameter int unsigned DATA_WIDTH = 16
);
  localparam int unsigned NUM_REGS = 1 << ADDR_SIZE;

  logic                  a_valid;
  logic                  a_ready;
  logic [ADDR_SIZE-1:0]  a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [ADDR_SIZE-1:0]  m_addr;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  rf_w_en;
  logic [ADDR_SIZE-1:0]  rf_addr_c;
  logic [DATA_WIDTH-1:0] rf_data_c;
  logic [NUM_REGS-1:0]   busy_mask;

  modport master (
    output a_valid, a_addr, a_data, m_valid, m_addr, m_data,
    input  a_ready, m_ready, rf_w_en, rf_addr_c, rf_data_c, busy_mask
  );

  modport slave (
    input  a_valid, a_addr, a_data, m_valid, m_addr, m_data,
    output a_ready, m_ready, rf_w_en, rf_addr_c, rf_data_c, busy_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: per-source queues, round-robin single write port, pending-write mask.
// Define REGFILE_WB_R0_DISCARD_EN to treat register 0 as hard-wired (writes to it are dropped).
module regfile_wb_arbiter #(
  parameter int unsigned ADDR_SIZE  = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 2
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned NUM_REGS = 1 << ADDR_SIZE;
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
`ifdef REGFILE_WB_R0_DISCARD_EN
  localparam bit R0_DISCARD = 1'b1;
`else
  localparam bit R0_DISCARD = 1'b0;
`endif

  typedef enum logic {GRANT_A, GRANT_M} grant_t;

  grant_t                last_grant;
  grant_t                last_grant_nxt;
  logic [1:0]            in_valid;
  logic [1:0]            ready;
  logic [1:0]            non_empty;
  logic [1:0]            pop;
  logic [ADDR_SIZE-1:0]  in_addr   [2];
  logic [DATA_WIDTH-1:0] in_data   [2];
  logic [ADDR_SIZE-1:0]  head_addr [2];
  logic [DATA_WIDTH-1:0] head_data [2];
  logic [NUM_REGS-1:0]   src_busy  [2];
  logic [NUM_REGS-1:0]   wb_busy;
  logic                  w_en_q;
  logic [ADDR_SIZE-1:0]  addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Index 0 is the ALU source, index 1 the load unit.
  assign in_valid   = {bus.m_valid, bus.a_valid};
  assign in_addr[0] = bus.a_addr;
  assign in_addr[1] = bus.m_addr;
  assign in_data[0] = bus.a_data;
  assign in_data[1] = bus.m_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [ADDR_SIZE-1:0]  mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0]      vld;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic [NUM_REGS-1:0]   busy;

    // Beats to register 0 still handshake when discarding, but are never stored.
    assign ready[s]     = count < CNT_W'(DEPTH);
    assign non_empty[s] = count != '0;
    assign push         = in_valid[s] && ready[s] && !(R0_DISCARD && (in_addr[s] == '0));
    assign head_addr[s] = mem_addr[rd_ptr];
    assign head_data[s] = mem_data[rd_ptr];

    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        vld    <= '0;
      end else begin
        if (pop[s]) begin
          rd_ptr      <= ptr_inc(rd_ptr);
          vld[rd_ptr] <= 1'b0;
        end
        if (push) begin
          wr_ptr      <= ptr_inc(wr_ptr);
          vld[wr_ptr] <= 1'b1;
        end
        count <= count + CNT_W'(push) - CNT_W'(pop[s]);
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        mem_addr[wr_ptr] <= in_addr[s];
        mem_data[wr_ptr] <= in_data[s];
      end
    end

    always_comb begin
      busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (vld[i]) busy[mem_addr[i]] = 1'b1;
      end
    end

    assign src_busy[s] = busy;
  end

  always_ff @(posedge clk) begin
    if (!rst) last_grant <= GRANT_M;
    else      last_grant <= last_grant_nxt;
  end

  // Round-robin: on contention the source not granted last time wins.
  always_comb begin
    last_grant_nxt = last_grant;
    pop            = 2'b00;
    if (non_empty[0] && (!non_empty[1] || (last_grant == GRANT_M))) begin
      pop            = 2'b01;
      last_grant_nxt = GRANT_A;
    end else if (non_empty[1]) begin
      pop            = 2'b10;
      last_grant_nxt = GRANT_M;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_en_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      w_en_q <= |pop;
      if (pop[0]) begin
        addr_q <= head_addr[0];
        data_q <= head_data[0];
      end else if (pop[1]) begin
        addr_q <= head_addr[1];
        data_q <= head_data[1];
      end
    end
  end

  always_comb begin
    wb_busy = '0;
    if (w_en_q) wb_busy[addr_q] = 1'b1;
  end

  assign bus.a_ready   = ready[0];
  assign bus.m_ready   = ready[1];
  assign bus.rf_w_en   = w_en_q;
  assign bus.rf_addr_c = addr_q;
  assign bus.rf_data_c = data_q;
  assign bus.busy_mask = src_busy[0] | src_busy[1] | wb_busy;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, latency, round-robin, backpressure, mid-run reset, r0 handling.
module tb_regfile_wb_arbiter;
  localparam int unsigned ADDR_SIZE  = 4;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned DEPTH      = 2;
`ifdef REGFILE_WB_R0_DISCARD_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.ADDR_SIZE(ADDR_SIZE), .DATA_WIDTH(DATA_WIDTH)) bus();

  regfile_wb_arbiter #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0;
    bus.a_addr  = '0;
    bus.a_data  = '0;
    bus.m_valid = 1'b0;
    bus.m_addr  = '0;
    bus.m_data  = '0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wen"},    32'(bus.rf_w_en),   0);
    check({tag, "_busy"},   32'(bus.busy_mask), 0);
    check({tag, "_aready"}, 32'(bus.a_ready),   1);
    check({tag, "_mready"}, 32'(bus.m_ready),   1);
  endtask

  task automatic check_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, "_wen"},  32'(bus.rf_w_en),   1);
    check({tag, "_addr"}, 32'(bus.rf_addr_c), addr);
    check({tag, "_data"}, 32'(bus.rf_data_c), data);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  logic [31:0] exp_a[$];
  logic [31:0] exp_m[$];
  int acc_a, acc_m, wr_a, wr_m, writes, cyc;

  // Account for one observed write against the per-source expected queues.
  task automatic score_write();
    logic [31:0] got;
    got = 32'({bus.rf_addr_c, bus.rf_data_c});
    writes++;
    if (bus.rf_addr_c < 4'd8) begin
      check("bp_a_queued", 32'(exp_a.size() != 0), 1);
      if (exp_a.size() != 0) check("bp_a_order", got, exp_a.pop_front());
      wr_a++;
    end else begin
      check("bp_m_queued", 32'(exp_m.size() != 0), 1);
      if (exp_m.size() != 0) check("bp_m_order", got, exp_m.pop_front());
      wr_m++;
    end
  endtask

  initial begin
    idle_inputs();

    // Reset held two cycles, then idle.
    rst = 1'b0;
    step();
    check_idle("rst0");
    check("rst0_addr", 32'(bus.rf_addr_c), 0);
    check("rst0_data", 32'(bus.rf_data_c), 0);
    step();
    check_idle("rst1");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("idle");
    end

    // Single ALU write: busy after E, write after E+1, gone after E+2.
    bus.a_valid = 1'b1;
    bus.a_addr  = 4'd3;
    bus.a_data  = 16'hBEEF;
    check("sw_ready", 32'(bus.a_ready), 1);
    step();
    idle_inputs();
    check("sw_busy_e1", 32'(bus.busy_mask), 32'h0008);
    check("sw_wen_e1",  32'(bus.rf_w_en),   0);
    step();
    check_write("sw_e2", 3, 32'hBEEF);
    check("sw_busy_e2", 32'(bus.busy_mask), 32'h0008);
    step();
    check("sw_wen_e3",  32'(bus.rf_w_en),   0);
    check("sw_busy_e3", 32'(bus.busy_mask), 0);
    check("sw_hold_addr", 32'(bus.rf_addr_c), 3);
    check("sw_hold_data", 32'(bus.rf_data_c), 32'hBEEF);

    // Contention from a fresh reset: A wins first, then alternation.
    do_reset();
    bus.a_valid = 1'b1; bus.a_addr = 4'd1; bus.a_data = 16'h0001;
    bus.m_valid = 1'b1; bus.m_addr = 4'd5; bus.m_data = 16'h0005;
    step();
    bus.a_addr = 4'd2; bus.a_data = 16'h0002;
    bus.m_addr = 4'd6; bus.m_data = 16'h0006;
    check("rr_a_ready", 32'(bus.a_ready), 1);
    check("rr_m_ready", 32'(bus.m_ready), 1);
    step();
    idle_inputs();
    check_write("rr_w0", 1, 1);
    step();
    check_write("rr_w1", 5, 5);
    step();
    check_write("rr_w2", 2, 2);
    step();
    check_write("rr_w3", 6, 6);
    step();
    check("rr_done_wen", 32'(bus.rf_w_en), 0);
    check("rr_done_busy", 32'(bus.busy_mask), 0);

    // Both sources saturated; A uses regs 1..7, M uses regs 8..15.
    acc_a = 0; acc_m = 0; wr_a = 0; wr_m = 0; writes = 0; cyc = 0;
    bus.a_valid = 1'b1;
    bus.m_valid = 1'b1;
    while (writes < 20 && cyc < 200) begin
      bus.a_addr = 4'(1 + acc_a % 7);
      bus.a_data = 16'hA000 + 16'(acc_a);
      bus.m_addr = 4'(8 + acc_m % 8);
      bus.m_data = 16'hB000 + 16'(acc_m);
      if (bus.a_ready) begin
        exp_a.push_back(32'({bus.a_addr, bus.a_data}));
        acc_a++;
      end
      if (bus.m_ready) begin
        exp_m.push_back(32'({bus.m_addr, bus.m_data}));
        acc_m++;
      end
      step();
      cyc++;
      if (bus.rf_w_en) score_write();
      check("bp_a_ready", 32'(bus.a_ready), 32'((acc_a - wr_a) < 2));
      check("bp_m_ready", 32'(bus.m_ready), 32'((acc_m - wr_m) < 2));
    end
    check("bp_writes", 32'(writes), 20);
    check("bp_share_a", 32'(wr_a), 10);
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.rf_w_en) score_write();
    end
    check("bp_drain_a", 32'(exp_a.size()), 0);
    check("bp_drain_m", 32'(exp_m.size()), 0);
    check("bp_drain_busy", 32'(bus.busy_mask), 0);

    // Reset while both queues hold work: nothing queued may ever be written.
    bus.a_valid = 1'b1; bus.a_addr = 4'd7;  bus.a_data = 16'h7777;
    bus.m_valid = 1'b1; bus.m_addr = 4'd15; bus.m_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) step();
    do_reset();
    check_idle("mr");
    check("mr_addr", 32'(bus.rf_addr_c), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("mr_flushed_wen", 32'(bus.rf_w_en), 0);
    end
    bus.a_valid = 1'b1; bus.a_addr = 4'd4; bus.a_data = 16'h4444;
    bus.m_valid = 1'b1; bus.m_addr = 4'd9; bus.m_data = 16'h9999;
    step();
    idle_inputs();
    check("mr_busy", 32'(bus.busy_mask), 32'h0210);
    step();
    check_write("mr_first", 4, 32'h4444);
    step();
    check_write("mr_second", 9, 32'h9999);
    step();
    check("mr_end_wen", 32'(bus.rf_w_en), 0);

    // Load write to register 0: dropped when r0 is hard-wired, else a normal write.
    bus.m_valid = 1'b1; bus.m_addr = 4'd0; bus.m_data = 16'h1234;
    check("r0_ready", 32'(bus.m_ready), 1);
    step();
    idle_inputs();
    check("r0_busy_e1", 32'(bus.busy_mask), R0 ? 0 : 1);
    check("r0_wen_e1", 32'(bus.rf_w_en), 0);
    step();
    check("r0_wen_e2", 32'(bus.rf_w_en), R0 ? 0 : 1);
    if (!R0) begin
      check("r0_addr", 32'(bus.rf_addr_c), 0);
      check("r0_data", 32'(bus.rf_data_c), 32'h1234);
    end
    step();
    check("r0_wen_e3", 32'(bus.rf_w_en), 0);
    check("r0_busy_e3", 32'(bus.busy_mask), 0);
    check("r0_mready_e3", 32'(bus.m_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
